cskip_adder_pipe: RTL

CSKIP_ADDER_PIPE -- requirements
Module: cskip_adder_pipe

---
 rtl/cskip_pkg.sv | 14 +
 rtl/cskip_blk.sv | 28 ++
 rtl/cskip_adder_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/cskip_pkg.sv
// cskip_pkg: shared constants and pipeline stage record for the carry-skip adder
// Record layout: sa holds finished sum bits below the current block and raw A bits above it,
// b holds effective B, c is the carry into the next block, cm the carry into the MSB.
package cskip_pkg;
  localparam int CSKIP_WIDTH = 16;
  localparam int CSKIP_BLK   = 4;
  typedef struct packed {
    logic                   valid;
    logic                   c;
    logic                   cm;
    logic [CSKIP_WIDTH-1:0] sa;
    logic [CSKIP_WIDTH-1:0] b;
  } stage_t;
endpackage

// File: rtl/cskip_blk.sv
// cskip_blk: combinational BLK-bit ripple block with carry-skip mux
// Ports: a_i, b_i operand slices; c_i block carry-in; s_o slice sum;
//        c_o block carry-out (c_i when the whole block propagates); cm_o carry into the block MSB.
module cskip_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           c_i,
  output logic [BLK-1:0] s_o,
  output logic           c_o,
  output logic           cm_o
);
  logic rc;
  logic p;
  always_comb begin
    rc   = c_i;
    cm_o = 1'b0;
    s_o  = '0;
    for (int k = 0; k < BLK; k++) begin
      s_o[k] = a_i[k] ^ b_i[k] ^ rc;
      cm_o   = rc;
      rc     = (a_i[k] & b_i[k]) | ((a_i[k] ^ b_i[k]) & rc);
    end
  end
  assign p   = &(a_i ^ b_i);
  assign c_o = p ? c_i : rc;
endmodule

// File: rtl/cskip_adder_pipe.sv
// cskip_adder_pipe: NBLK-stage pipelined carry-skip adder/subtractor, one block per stage
// Ports: clk; rst_n sync active-low; in_valid/in_ready with a, b, cin, sub (1 = a-b);
//        out_valid/out_ready with sum, cout, ovf; skip_cnt only when CSKIP_STATS_EN is defined.
// The stage record width follows cskip_pkg::CSKIP_WIDTH, so WIDTH changes go through the package.
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int WIDTH = CSKIP_WIDTH,
  parameter int BLK   = CSKIP_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CSKIP_STATS_EN
  ,
  output logic [31:0]      skip_cnt
`endif
);
  localparam int NBLK = WIDTH / BLK;
  stage_t           src_w [NBLK];
  stage_t           st_d  [NBLK];
  stage_t           st_q  [NBLK];
  logic [WIDTH-1:0] eff_b;
  logic [WIDTH-1:0] s_w;
  logic [NBLK-1:0]  co_w;
  logic [NBLK-1:0]  cm_w;
  assign eff_b     = sub ? ~b : b;
  assign out_valid = st_q[NBLK-1].valid;
  assign in_ready  = !out_valid || out_ready;
  assign sum       = st_q[NBLK-1].sa;
  assign cout      = st_q[NBLK-1].c;
  assign ovf       = st_q[NBLK-1].c ^ st_q[NBLK-1].cm;
  genvar i;
  for (i = 0; i < NBLK; i++) begin : g_blk
    if (i == 0) begin : g_head
      assign src_w[i] = '{valid: in_valid, c: sub | cin, cm: 1'b0, sa: a, b: eff_b};
    end else begin : g_body
      assign src_w[i] = st_q[i-1];
    end
    cskip_blk #(.BLK(BLK)) u_blk (
      .a_i  (src_w[i].sa[i*BLK +: BLK]),
      .b_i  (src_w[i].b[i*BLK +: BLK]),
      .c_i  (src_w[i].c),
      .s_o  (s_w[i*BLK +: BLK]),
      .c_o  (co_w[i]),
      .cm_o (cm_w[i])
    );
  end
  // each stage overwrites its own slice of sa with sum bits and forwards the block carry
  always_comb
    for (int k = 0; k < NBLK; k++) begin
      st_d[k]                  = src_w[k];
      st_d[k].sa[k*BLK +: BLK] = s_w[k*BLK +: BLK];
      st_d[k].c                = co_w[k];
      st_d[k].cm               = cm_w[k];
    end
  // a blocked output freezes the whole pipe, bubbles included
  always_ff @(posedge clk)
    if (!rst_n)
      for (int k = 0; k < NBLK; k++) st_q[k] <= '0;
    else if (in_ready)
      for (int k = 0; k < NBLK; k++) st_q[k] <= st_d[k];
`ifdef CSKIP_STATS_EN
  logic [31:0] skip_cnt_q;
  logic [31:0] skip_cnt_d;
  logic [32:0] acc;
  // skip flags are taken from the operands at acceptance, one extra bit catches saturation
  always_comb begin
    acc = {1'b0, skip_cnt_q};
    if (in_valid && in_ready)
      for (int k = 0; k < NBLK; k++) acc = acc + 33'(&(a[k*BLK +: BLK] ^ eff_b[k*BLK +: BLK]));
    skip_cnt_d = acc[32] ? '1 : acc[31:0];
  end
  always_ff @(posedge clk)
    if (!rst_n) skip_cnt_q <= '0;
    else skip_cnt_q <= skip_cnt_d;
  assign skip_cnt = skip_cnt_q;
`endif
endmodule
